// File: rtl/fft_load_addr_gen_if.sv
// Address-pair stream between the FFT load address generator and the RAM ports.
// The master drives valid and the pair. The slave drives ready.
interface fft_load_addr_gen_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                  addr_valid;
   logic                  addr_ready;
   logic [ADDR_WIDTH-1:0] src_addr;
   logic [ADDR_WIDTH-1:0] dst_addr;

   modport master (
      output addr_valid,
      output src_addr,
      output dst_addr,
      input  addr_ready
   );

   modport slave (
      input  addr_valid,
      input  src_addr,
      input  dst_addr,
      output addr_ready
   );
endinterface

// File: rtl/fft_load_addr_gen.sv
// FFT input-load address generator: per frame emits 2^N (src, dst) pairs,
// dst bit-reversed over N bits or natural, plus a fixed offset, with valid/ready.
module fft_load_addr_gen #(
   parameter int ADDR_WIDTH = 12,
   parameter int STAGE_W    = 4,
   parameter int DST_OFFSET = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [STAGE_W-1:0] stage_number,
   input  logic               bitrev_en,
   output logic               busy,
   output logic               done,
   fft_load_addr_gen_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [STAGE_W-1:0]    AW_N   = STAGE_W'(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] OFFSET = ADDR_WIDTH'(DST_OFFSET);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] r_dst;
   logic                  r_valid;
   logic                  r_busy;
   logic                  r_done;
   logic [STAGE_W-1:0]    r_n;
   logic                  r_bitrev;

   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] w_cnt_nxt;
   logic [ADDR_WIDTH-1:0] w_dst_nxt;
   logic                  w_valid_nxt;
   logic                  w_busy_nxt;
   logic                  w_done_nxt;
   logic [STAGE_W-1:0]    w_n_nxt;
   logic                  w_bitrev_nxt;
   logic [STAGE_W-1:0]    w_n_start;
   logic [ADDR_WIDTH-1:0] w_cnt_inc;
   logic [ADDR_WIDTH-1:0] w_last;
   logic                  w_xfer;

   // N = 0 is promoted to a 2-point frame; anything beyond the address space is capped.
   function automatic logic [STAGE_W-1:0] clamp_n(input logic [STAGE_W-1:0] sn);
      logic [STAGE_W-1:0] n;
      if (sn == '0)
         n = STAGE_W'(1);
      else if (sn > AW_N)
         n = AW_N;
      else
         n = sn;
      return n;
   endfunction

   // Full-width reversal followed by a right shift equals reversal over the low
   // N bits, because the index never has bits set at or above N.
   function automatic logic [ADDR_WIDTH-1:0] map_dst(
      input logic [ADDR_WIDTH-1:0] idx,
      input logic [STAGE_W-1:0]    n,
      input logic                  brev
   );
      logic [ADDR_WIDTH-1:0] rev;
      for (int k = 0; k < ADDR_WIDTH; k++)
         rev[k] = idx[ADDR_WIDTH-1-k];
      rev = rev >> (AW_N - n);
      return (brev ? rev : idx) + OFFSET;
   endfunction

   assign w_n_start = clamp_n(stage_number);
   assign w_cnt_inc = r_cnt + ADDR_WIDTH'(1);
   assign w_last    = {ADDR_WIDTH{1'b1}} >> (AW_N - r_n);
   assign w_xfer    = r_valid & bus.addr_ready;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; a missing default here would infer a latch.
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_dst_nxt    = r_dst;
      w_valid_nxt  = r_valid;
      w_done_nxt   = 1'b0;
      w_n_nxt      = r_n;
      w_bitrev_nxt = r_bitrev;

      case (r_state)
         S_IDLE: begin
            if (start && !abort) begin
               w_n_nxt      = w_n_start;
               w_bitrev_nxt = bitrev_en;
               w_cnt_nxt    = '0;
               w_dst_nxt    = map_dst('0, w_n_start, bitrev_en);
               w_valid_nxt  = 1'b1;
               w_state_nxt  = S_RUN;
            end
         end

         S_RUN: begin
            // Abort wins over a transfer that would otherwise happen this edge.
            if (abort) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = S_IDLE;
            end else if (w_xfer) begin
               if (r_cnt == w_last) begin
                  w_valid_nxt = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_DONE;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
                  w_dst_nxt = map_dst(w_cnt_inc, r_n, r_bitrev);
               end
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_valid_nxt = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_dst    <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_n      <= '0;
         r_bitrev <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_dst    <= w_dst_nxt;
         r_valid  <= w_valid_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_n      <= w_n_nxt;
         r_bitrev <= w_bitrev_nxt;
      end
   end

   assign bus.addr_valid = r_valid;
   assign bus.src_addr   = r_cnt;
   assign bus.dst_addr   = r_dst;
   assign busy           = r_busy;
   assign done           = r_done;

endmodule
